// File: rtl/gc_stream_packer_pkg.sv
// Shared definitions for the garbler output packer: record tags, packer
// FSM states and the tag -> payload word count mapping.
package gc_stream_packer_pkg;

    localparam logic [2:0] TAG_NONE     = 3'b000;
    localparam logic [2:0] TAG_KEYS     = 3'b001;
    localparam logic [2:0] TAG_GT       = 3'b010;
    localparam logic [2:0] TAG_MASK     = 3'b011;
    localparam logic [2:0] TAG_HDR_ONLY = 3'b100;
    localparam logic [2:0] TAG_IN0      = 3'b101;
    localparam logic [2:0] TAG_IN1      = 3'b110;
    localparam logic [2:0] TAG_IN01     = 3'b111;

    // State names the word currently held in the output register.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_D0   = 2'd2,
        ST_D1   = 2'd3
    } pack_state_e;

    // Number of payload words that follow the header for a given tag.
    function automatic logic [1:0] payload_words(input logic [2:0] tag);
        case (tag)
            TAG_IN0, TAG_IN1:                    return 2'd1;
            TAG_KEYS, TAG_GT, TAG_MASK, TAG_IN01: return 2'd2;
            TAG_NONE, TAG_HDR_ONLY:              return 2'd0;
            default:                             return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/gc_stream_packer_fifo.sv
// Single-clock record FIFO. Exposes both the head entry and the entry behind
// it so the packer can load the next header in the same cycle it retires the
// current record (no bubble between back-to-back records).
module gc_rec_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head_data,
    output logic [W-1:0]             next_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next_ptr;
    logic [CW-1:0] count_q, count_d;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
        rd_next_ptr = rd_ptr_q + AW'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are qualified by the pointers so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign next_data = mem_q[rd_next_ptr];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));

endmodule

// File: rtl/gc_stream_packer.sv
// Buffers garbler output records and serializes each one as a header word
// followed by zero, one or two payload words on a valid/ready link.
// Handshake: a word moves when out_valid && out_ready; while out_valid is
// high and out_ready low, out_data/out_last/out_valid hold, and out_valid
// only falls after a transfer.
module gc_stream_packer
    import gc_stream_packer_pkg::*;
#(
    parameter int S        = 20,
    parameter int K        = 128,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   tag,
    input  logic [S-1:0] cid,
    input  logic [S-1:0] index0,
    input  logic [S-1:0] index1,
    input  logic [K-1:0] data0,
    input  logic [K-1:0] data1,
    output logic [K-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         almost_full,
    output logic         overflow,
    output logic [S-1:0] drop_count
);

    localparam int HW = 3 + 3 * S;          // header field bits
    localparam int RW = HW + 2 * K;         // stored record width
    localparam int CW = $clog2(DEPTH) + 1;

    logic [RW-1:0] in_rec, head_rec, next_rec, sel_rec;
    logic [CW-1:0] occ, occ_next;
    logic          fifo_full, rec_valid, fire, retire, push_ok;
    logic          sel_avail, load_hdr;
    logic [2:0]    head_tag;
    logic [K-1:0]  head_d0, head_d1;

    pack_state_e   state_q, state_d;
    logic [K-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;
    logic [S-1:0]  drop_q, drop_d;

    // Header: tag, cid, index0, index1 packed from the MSB down, zero below.
    function automatic logic [K-1:0] make_header(input logic [RW-1:0] rec);
        logic [K-1:0] h;
        h = '0;
        h[K-1 -: HW] = rec[RW-1 -: HW];
        return h;
    endfunction

    assign in_rec    = {tag, cid, index0, index1, data0, data1};
    assign rec_valid = (tag != TAG_NONE);
    assign fire      = out_valid_q && out_ready;
    assign retire    = fire && out_last_q;
    // A full FIFO still takes a record when the head retires this cycle.
    assign push_ok   = rec_valid && (!fifo_full || retire);

    assign head_tag  = head_rec[RW-1 -: 3];
    assign head_d0   = head_rec[2*K-1:K];
    assign head_d1   = head_rec[K-1:0];

    gc_rec_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .pop       (retire),
        .wdata     (in_rec),
        .head_data (head_rec),
        .next_data (next_rec),
        .count     (occ),
        .full      (fifo_full)
    );

    // Pick the record whose header is presented next: the entry behind a
    // retiring head, the current head, or the incoming record when the FIFO
    // would otherwise be empty.
    always_comb begin
        sel_rec   = head_rec;
        sel_avail = 1'b0;
        if (retire) begin
            if (occ >= CW'(2)) begin
                sel_rec   = next_rec;
                sel_avail = 1'b1;
            end else if (push_ok) begin
                sel_rec   = in_rec;
                sel_avail = 1'b1;
            end
        end else begin
            if (occ != '0) begin
                sel_rec   = head_rec;
                sel_avail = 1'b1;
            end else if (push_ok) begin
                sel_rec   = in_rec;
                sel_avail = 1'b1;
            end
        end
    end

    // Packer FSM next state and output word selection.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        load_hdr    = 1'b0;
        case (state_q)
            ST_IDLE: load_hdr = 1'b1;
            default: begin
                if (fire) begin
                    if (out_last_q) begin
                        load_hdr = 1'b1;
                    end else if (state_q == ST_HDR && head_tag != TAG_IN1) begin
                        state_d    = ST_D0;
                        out_data_d = head_d0;
                        out_last_d = (payload_words(head_tag) == 2'd1);
                    end else begin
                        state_d    = ST_D1;
                        out_data_d = head_d1;
                        out_last_d = 1'b1;
                    end
                end
            end
        endcase
        if (load_hdr) begin
            if (sel_avail) begin
                state_d     = ST_HDR;
                out_valid_d = 1'b1;
                out_data_d  = make_header(sel_rec);
                out_last_d  = (payload_words(sel_rec[RW-1 -: 3]) == 2'd0);
            end else begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    // Status: almost_full tracks next occupancy, drops are sticky/saturating.
    always_comb begin
        occ_next = occ + CW'(push_ok) - CW'(retire);
        af_d     = (occ_next >= CW'(AF_LEVEL));
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (rec_valid && !push_ok) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + S'(1);
        end
    end

    // State, output and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            af_q        <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            af_q        <= af_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_gc_stream_packer.sv
// Bench for gc_stream_packer: table of single-record vectors plus directed
// sequences for back-to-back, stall, overflow, full+retire and mid-record reset.
module tb_gc_stream_packer;

    localparam int S        = 20;
    localparam int K        = 128;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int KW       = K + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   tag = '0;
    logic [S-1:0] cid = '0, index0 = '0, index1 = '0;
    logic [K-1:0] data0 = '0, data1 = '0;
    logic [K-1:0] out_data;
    logic         out_valid, out_ready = 1'b0, out_last;
    logic         almost_full, overflow;
    logic [S-1:0] drop_count;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    gc_stream_packer #(
        .S(S), .K(K), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tag         (tag),
        .cid         (cid),
        .index0      (index0),
        .index1      (index1),
        .data0       (data0),
        .data1       (data1),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    typedef struct {
        logic [2:0]   tag;
        logic [S-1:0] cid;
        logic [S-1:0] i0;
        logic [S-1:0] i1;
        logic [K-1:0] d0;
        logic [K-1:0] d1;
        int           exp_n;     // total words incl. header
        logic         w1_is_d1;  // second word is data1 rather than data0
    } vec_t;

    vec_t vecs[7];

    // Scoreboard: {out_last, out_data} per expected word.
    logic [K:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [K:0] act, input logic [K:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Header layout for K=128, S=20.
    function automatic logic [K-1:0] hdr(input logic [2:0] t, input logic [S-1:0] c,
                                         input logic [S-1:0] a, input logic [S-1:0] b);
        logic [K-1:0] h;
        h = '0;
        h[127:125] = t;
        h[124:105] = c;
        h[104:85]  = a;
        h[84:65]   = b;
        return h;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rec(input logic [2:0] t, input logic [S-1:0] c, input logic [S-1:0] a,
                             input logic [S-1:0] b, input logic [K-1:0] x, input logic [K-1:0] y);
        tag = t; cid = c; index0 = a; index1 = b; data0 = x; data1 = y;
    endtask

    task automatic idle_in();
        tag = 3'b000;
    endtask

    task automatic push_exp(input logic [2:0] t, input logic [S-1:0] c, input logic [S-1:0] a,
                            input logic [S-1:0] b, input logic [K-1:0] x, input logic [K-1:0] y);
        case (t)
            3'b100: exp_q.push_back({1'b1, hdr(t, c, a, b)});
            3'b101: begin
                exp_q.push_back({1'b0, hdr(t, c, a, b)});
                exp_q.push_back({1'b1, x});
            end
            3'b110: begin
                exp_q.push_back({1'b0, hdr(t, c, a, b)});
                exp_q.push_back({1'b1, y});
            end
            default: begin
                exp_q.push_back({1'b0, hdr(t, c, a, b)});
                exp_q.push_back({1'b0, x});
                exp_q.push_back({1'b1, y});
            end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int i = 0;
        while (exp_q.size() != 0 && i < max_cyc) begin
            step();
            i++;
        end
        check(name, KW'(exp_q.size()), '0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : mon
        logic [K:0] e;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %0h expected none", out_data);
            end else begin
                e = exp_q.pop_front();
                check("word", {out_last, out_data}, e);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{3'b001, 20'h00011, 20'h00001, 20'h00002, 128'hA, 128'hB, 3, 1'b0};
        vecs[1] = '{3'b101, 20'h00022, 20'h00005, 20'h00007, 128'h55, 128'h66, 2, 1'b0};
        vecs[2] = '{3'b110, 20'h00033, 20'h00003, 20'h00009, 128'h77, 128'h88, 2, 1'b1};
        vecs[3] = '{3'b111, 20'hFFFFF, 20'h12345, 20'hABCDE, {4{32'hDEADBEEF}}, {4{32'hCAFEF00D}}, 3, 1'b0};
        vecs[4] = '{3'b010, 20'h00044, 20'h00010, 20'h00020, 128'h1234, 128'h5678, 3, 1'b0};
        vecs[5] = '{3'b011, 20'h00055, 20'h000AA, 20'h000BB, 128'h9, 128'h8, 3, 1'b0};
        vecs[6] = '{3'b100, 20'h00066, 20'h00001, 20'hFFFFF, 128'h1, 128'h2, 1, 1'b0};

        // reset
        #1 rst = 1'b0;
        step();
        step();
        check("reset_out_valid", KW'(out_valid), '0);
        check("reset_out_last", KW'(out_last), '0);
        check("reset_out_data", KW'(out_data), '0);
        check("reset_almost_full", KW'(almost_full), '0);
        check("reset_overflow", KW'(overflow), '0);
        check("reset_drop_count", KW'(drop_count), '0);
        rst = 1'b1;
        step();

        // table: one record at a time, out_ready high
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            drive_rec(vecs[v].tag, vecs[v].cid, vecs[v].i0, vecs[v].i1, vecs[v].d0, vecs[v].d1);
            exp_q.push_back({vecs[v].exp_n == 1, hdr(vecs[v].tag, vecs[v].cid, vecs[v].i0, vecs[v].i1)});
            if (vecs[v].exp_n >= 2)
                exp_q.push_back({vecs[v].exp_n == 2, vecs[v].w1_is_d1 ? vecs[v].d1 : vecs[v].d0});
            if (vecs[v].exp_n == 3)
                exp_q.push_back({1'b1, vecs[v].d1});
            step();
            idle_in();
            check("latency_valid", KW'(out_valid), KW'(1));
            check("latency_hdr", KW'(out_data), KW'(hdr(vecs[v].tag, vecs[v].cid, vecs[v].i0, vecs[v].i1)));
            check("hdr_index0_field", KW'(out_data[104:85]), KW'(vecs[v].i0));
            wait_drain(10, "table_drain");
        end

        // back-to-back: 3 + 2 + 1 words with no bubble
        drive_rec(3'b001, 20'h101, 20'h1, 20'h2, 128'h111, 128'h222);
        push_exp(3'b001, 20'h101, 20'h1, 20'h2, 128'h111, 128'h222);
        step();
        check("b2b_valid", KW'(out_valid), KW'(1));
        drive_rec(3'b101, 20'h102, 20'h3, 20'h4, 128'h333, 128'h444);
        push_exp(3'b101, 20'h102, 20'h3, 20'h4, 128'h333, 128'h444);
        step();
        check("b2b_valid", KW'(out_valid), KW'(1));
        drive_rec(3'b100, 20'h103, 20'h5, 20'h6, 128'h555, 128'h666);
        push_exp(3'b100, 20'h103, 20'h5, 20'h6, 128'h555, 128'h666);
        step();
        idle_in();
        check("b2b_valid", KW'(out_valid), KW'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            check("b2b_valid", KW'(out_valid), KW'(1));
        end
        step();
        check("b2b_idle_after", KW'(out_valid), '0);
        wait_drain(5, "b2b_drain");

        // stall with header pending
        out_ready = 1'b0;
        drive_rec(3'b011, 20'h2A2A2, 20'h00777, 20'h00888, 128'hC0DE, 128'hF00D);
        push_exp(3'b011, 20'h2A2A2, 20'h00777, 20'h00888, 128'hC0DE, 128'hF00D);
        step();
        idle_in();
        for (int i = 0; i < 10; i++) begin
            check("stall_data", KW'(out_data), KW'(hdr(3'b011, 20'h2A2A2, 20'h00777, 20'h00888)));
            check("stall_valid", KW'(out_valid), KW'(1));
            check("stall_last", KW'(out_last), '0);
            step();
        end
        out_ready = 1'b1;
        wait_drain(10, "stall_drain");

        // overflow: 18 pushes into a 16-deep FIFO with no drain
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive_rec(3'b010, S'(i + 1), S'(i), S'(i + 100), K'(1000 + i), K'(2000 + i));
            if (i < 16) push_exp(3'b010, S'(i + 1), S'(i), S'(i + 100), K'(1000 + i), K'(2000 + i));
            step();
            check("ovf_almost_full", KW'(almost_full), KW'((i + 1) >= AF_LEVEL));
        end
        idle_in();
        check("ovf_overflow", KW'(overflow), KW'(1));
        check("ovf_drop_count", KW'(drop_count), KW'(2));
        check("ovf_occupancy", KW'(dut.occ), KW'(16));
        out_ready = 1'b1;
        wait_drain(80, "ovf_drain");
        step();
        check("ovf_af_after_drain", KW'(almost_full), '0);
        check("ovf_sticky", KW'(overflow), KW'(1));

        // full plus retire: push accepted in the cycle the head retires
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_rec(3'b100, S'(i + 500), S'(i), S'(i), K'(0), K'(0));
            push_exp(3'b100, S'(i + 500), S'(i), S'(i), K'(0), K'(0));
            step();
        end
        idle_in();
        check("fr_occupancy_full", KW'(dut.occ), KW'(16));
        out_ready = 1'b1;
        drive_rec(3'b100, 20'h77777, 20'h1, 20'h2, K'(0), K'(0));
        push_exp(3'b100, 20'h77777, 20'h1, 20'h2, K'(0), K'(0));
        step();
        out_ready = 1'b0;
        idle_in();
        check("fr_occupancy", KW'(dut.occ), KW'(16));
        check("fr_drop_count", KW'(drop_count), '0);
        check("fr_overflow", KW'(overflow), '0);
        out_ready = 1'b1;
        wait_drain(40, "fr_drain");

        // reset in the middle of a record (D0 word pending)
        out_ready = 1'b0;
        drive_rec(3'b001, 20'h5A5A5, 20'h11111, 20'h22222, 128'hD0, 128'hD1);
        exp_q.push_back({1'b0, hdr(3'b001, 20'h5A5A5, 20'h11111, 20'h22222)});
        step();
        idle_in();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("mid_d0_present", {out_last, out_data}, {1'b0, 128'hD0});
        rst = 1'b0;
        #1;
        check("mid_rst_valid", KW'(out_valid), '0);
        check("mid_rst_occupancy", KW'(dut.occ), '0);
        check("mid_rst_overflow", KW'(overflow), '0);
        step();
        rst = 1'b1;
        step();
        step();
        check("mid_no_resume", KW'(out_valid), '0);
        out_ready = 1'b1;
        drive_rec(3'b110, 20'h0BEEF, 20'h00003, 20'h00004, 128'hE0, 128'hE1);
        push_exp(3'b110, 20'h0BEEF, 20'h00003, 20'h00004, 128'hE0, 128'hE1);
        step();
        idle_in();
        wait_drain(10, "mid_new_record");
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
